instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader_pkg.sv | 30 +++
 rtl/instr_loader_if.sv | 28 ++
 rtl/instr_loader_rv_encoder.sv | 63 ++++++
 rtl/instr_loader.sv | 112 +++++++++++
 tb/tb_instr_loader.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction loader: RV32I opcodes, descriptor kinds, FSM states.
package instr_loader_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_WORD   = 3'b010;
    localparam logic [2:0] F3_BEQ    = 3'b000;
    localparam logic [2:0] F3_SRX    = 3'b101;

    typedef enum logic [2:0] {
        K_LW    = 3'd0,
        K_SW    = 3'd1,
        K_RTYPE = 3'd2,
        K_BEQ   = 3'd3,
        K_IALU  = 3'd4,
        K_JAL   = 3'd5
    } kind_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/instr_loader_if.sv
// Descriptor stream (source -> loader) and instruction-memory write port (loader -> memory).
interface instr_loader_if #(
    parameter int ADDR_W = 6
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_kind;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic              in_funct7b5;
    logic [20:0]       in_imm;
    logic              in_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid, in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_funct7b5, in_imm, in_last,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_funct7b5, in_imm, in_last,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_loader_rv_encoder.sv
// Combinational RV32I encoder: descriptor fields -> 32-bit instruction word plus an illegal flag.
module rv_encoder
    import instr_loader_pkg::*;
(
    input  logic [2:0]  kind,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic [20:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    logic        w_fits_i;
    logic        w_fits_b;
    logic        w_fits_j;
    logic [6:0]  w_funct7;
    logic [11:0] w_imm_alu;

    // The 21-bit input is sign-extended; a field fits when every bit above its sign bit repeats it.
    assign w_fits_i  = (imm[20:11] == {10{imm[11]}});
    assign w_fits_b  = (imm[20:12] == {9{imm[12]}}) && !imm[0];
    assign w_fits_j  = !imm[0];
    assign w_funct7  = {1'b0, funct7b5, 5'b00000};
    assign w_imm_alu = (funct3 == F3_SRX) ? {w_funct7, imm[4:0]} : imm[11:0];

    // NOTE: both outputs get a default before the case so no path leaves them unassigned (no latch).
    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (kind)
            K_LW: begin
                word    = {imm[11:0], rs1, F3_WORD, rd, OP_LOAD};
                illegal = !w_fits_i;
            end
            K_SW: begin
                word    = {imm[11:5], rs2, rs1, F3_WORD, imm[4:0], OP_STORE};
                illegal = !w_fits_i;
            end
            K_RTYPE: begin
                word    = {w_funct7, rs2, rs1, funct3, rd, OP_OP};
            end
            K_BEQ: begin
                word    = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OP_BRANCH};
                illegal = !w_fits_b;
            end
            K_IALU: begin
                word    = {w_imm_alu, rs1, funct3, rd, OP_OP_IMM};
                illegal = !w_fits_i;
            end
            K_JAL: begin
                word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
                illegal = !w_fits_j;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_loader.sv
// Instruction loader: accepts descriptors during a load session, encodes them and writes
// consecutive instruction-memory words while holding the CPU.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    instr_loader_if.slave  bus,
    output logic           cpu_hold,
    output logic           done,
    output logic           err
);

    state_e            r_state;
    state_e            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_waddr;
    logic [31:0]       r_wdata;
    logic              r_we;
    logic              r_err;
    logic              r_final_pend;
    logic              r_start_pend;

    logic [31:0]       w_word;
    logic              w_illegal;
    logic              w_ready;
    logic              w_accept;
    logic              w_write;
    logic              w_full;
    logic              w_last_ok;
    logic              w_last_bad;
    logic              w_to_done;
    logic              w_enter_load;

    rv_encoder u_enc (
        .kind     (bus.in_kind),
        .rd       (bus.in_rd),
        .rs1      (bus.in_rs1),
        .rs2      (bus.in_rs2),
        .funct3   (bus.in_funct3),
        .funct7b5 (bus.in_funct7b5),
        .imm      (bus.in_imm),
        .word     (w_word),
        .illegal  (w_illegal)
    );

    assign w_ready      = (r_state == S_LOAD) && !r_final_pend;
    assign w_accept     = bus.in_valid && w_ready;
    assign w_write      = w_accept && !w_illegal;
    assign w_full       = &r_addr;
    assign w_last_ok    = w_write && (bus.in_last || w_full);
    assign w_last_bad   = w_accept && w_illegal && bus.in_last;
    assign w_to_done    = (r_state == S_LOAD) && (r_final_pend || w_last_bad);
    // A start coinciding with the move into DONE is remembered and acted on from DONE.
    assign w_enter_load = (r_state != S_LOAD) && (start || r_start_pend);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_enter_load) w_next = S_LOAD;
            S_LOAD:  if (w_to_done)    w_next = S_DONE;
            S_DONE:  if (w_enter_load) w_next = S_LOAD;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr       <= '0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_we         <= 1'b0;
            r_err        <= 1'b0;
            r_final_pend <= 1'b0;
            r_start_pend <= 1'b0;
        end else begin
            r_we         <= w_write;
            r_start_pend <= w_to_done && start;
            if (w_write) begin
                r_wdata <= w_word;
                r_waddr <= r_addr;
                if (!w_full) r_addr <= r_addr + 1'b1;
            end
            if (w_last_ok)      r_final_pend <= 1'b1;
            else if (w_to_done) r_final_pend <= 1'b0;
            if (w_accept && w_illegal) r_err <= 1'b1;
            if (w_enter_load) begin
                r_addr       <= '0;
                r_err        <= 1'b0;
                r_final_pend <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = w_ready;
    assign bus.imem_we    = r_we;
    assign bus.imem_addr  = r_waddr;
    assign bus.imem_wdata = r_wdata;
    assign cpu_hold       = (r_state != S_DONE);
    assign done           = (r_state == S_DONE);
    assign err            = r_err;

endmodule

// File: tb/tb_instr_loader.sv
// Directed self-checking bench for instr_loader (default depth and a 4-word instance).
module tb_instr_loader;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic hold_a, done_a, err_a;
    logic hold_b, done_b, err_b;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    instr_loader_if #(.ADDR_W(6)) if_a ();
    instr_loader_if #(.ADDR_W(2)) if_b ();

    instr_loader #(.ADDR_W(6)) u_dut (
        .clk(clk), .reset(reset), .start(start_a), .bus(if_a.slave),
        .cpu_hold(hold_a), .done(done_a), .err(err_a)
    );

    instr_loader #(.ADDR_W(2)) u_small (
        .clk(clk), .reset(reset), .start(start_b), .bus(if_b.slave),
        .cpu_hold(hold_b), .done(done_b), .err(err_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat_a(input logic [2:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [2:0] f3, input logic f7,
                          input int imm, input logic last);
        if_a.in_valid    = 1'b1;
        if_a.in_kind     = k;
        if_a.in_rd       = rd;
        if_a.in_rs1      = rs1;
        if_a.in_rs2      = rs2;
        if_a.in_funct3   = f3;
        if_a.in_funct7b5 = f7;
        if_a.in_imm      = imm[20:0];
        if_a.in_last     = last;
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        n_checks++; if (if_a.imem_we !== 1'b0) begin n_errors++; $display("FAIL rst_we: got %b want 0", if_a.imem_we); end
        n_checks++; if (if_a.imem_addr !== 6'd0) begin n_errors++; $display("FAIL rst_addr: got %0d want 0", if_a.imem_addr); end
        n_checks++; if (if_a.imem_wdata !== 32'h0) begin n_errors++; $display("FAIL rst_wdata: got %h want 0", if_a.imem_wdata); end
        n_checks++; if (if_a.in_ready !== 1'b0) begin n_errors++; $display("FAIL rst_ready: got %b want 0", if_a.in_ready); end
        n_checks++; if ({hold_a, done_a, err_a} !== 3'b100) begin n_errors++; $display("FAIL rst_status: got hold/done/err=%b want 100", {hold_a, done_a, err_a}); end
        reset = 1'b1;
        tick();
        n_checks++; if ({hold_a, done_a, if_a.in_ready} !== 3'b100) begin n_errors++; $display("FAIL idle_after_rst: got hold/done/ready=%b want 100", {hold_a, done_a, if_a.in_ready}); end
    endtask

    task automatic test_lw();
        pulse_start_a();
        n_checks++; if (if_a.in_ready !== 1'b1) begin n_errors++; $display("FAIL lw_ready: got %b want 1", if_a.in_ready); end
        beat_a(3'd0, 5'd5, 5'd2, 5'd0, 3'd0, 1'b0, 8, 1'b1);
        tick();
        if_a.in_valid = 1'b0;
        n_checks++; if (if_a.imem_we !== 1'b1) begin n_errors++; $display("FAIL lw_we: got %b want 1", if_a.imem_we); end
        n_checks++; if (if_a.imem_addr !== 6'd0) begin n_errors++; $display("FAIL lw_addr: got %0d want 0", if_a.imem_addr); end
        n_checks++; if (if_a.imem_wdata !== 32'h00812283) begin n_errors++; $display("FAIL lw_wdata: got %h want 00812283", if_a.imem_wdata); end
        tick();
        n_checks++; if ({if_a.imem_we, done_a} !== 2'b01) begin n_errors++; $display("FAIL lw_done: got we/done=%b want 01", {if_a.imem_we, done_a}); end
    endtask

    task automatic test_back_to_back();
        pulse_start_a();
        beat_a(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 0, 1'b0);
        tick();
        n_checks++; if ({if_a.imem_we, if_a.imem_addr} !== {1'b1, 6'd0}) begin n_errors++; $display("FAIL add_we_addr: got %b/%0d want 1/0", if_a.imem_we, if_a.imem_addr); end
        n_checks++; if (if_a.imem_wdata !== 32'h002081B3) begin n_errors++; $display("FAIL add_wdata: got %h want 002081B3", if_a.imem_wdata); end
        beat_a(3'd1, 5'd0, 5'd0, 5'd3, 3'd0, 1'b0, 12, 1'b1);
        tick();
        if_a.in_valid = 1'b0;
        n_checks++; if ({if_a.imem_we, if_a.imem_addr} !== {1'b1, 6'd1}) begin n_errors++; $display("FAIL sw_we_addr: got %b/%0d want 1/1", if_a.imem_we, if_a.imem_addr); end
        n_checks++; if (if_a.imem_wdata !== 32'h00302623) begin n_errors++; $display("FAIL sw_wdata: got %h want 00302623", if_a.imem_wdata); end
        n_checks++; if ({if_a.in_ready, done_a, hold_a} !== 3'b001) begin n_errors++; $display("FAIL sw_pending: got ready/done/hold=%b want 001", {if_a.in_ready, done_a, hold_a}); end
        tick();
        n_checks++; if ({done_a, hold_a} !== 2'b10) begin n_errors++; $display("FAIL sw_done: got done/hold=%b want 10", {done_a, hold_a}); end
    endtask

    task automatic test_branch_jal_start_at_done();
        pulse_start_a();
        beat_a(3'd3, 5'd0, 5'd1, 5'd1, 3'd0, 1'b0, -4, 1'b0);
        tick();
        n_checks++; if ({if_a.imem_we, if_a.imem_addr, if_a.imem_wdata} !== {1'b1, 6'd0, 32'hFE108EE3}) begin n_errors++; $display("FAIL beq: got we=%b addr=%0d data=%h want 1/0/FE108EE3", if_a.imem_we, if_a.imem_addr, if_a.imem_wdata); end
        beat_a(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 2048, 1'b1);
        tick();
        if_a.in_valid = 1'b0;
        n_checks++; if ({if_a.imem_we, if_a.imem_addr, if_a.imem_wdata} !== {1'b1, 6'd1, 32'h001000EF}) begin n_errors++; $display("FAIL jal: got we=%b addr=%0d data=%h want 1/1/001000EF", if_a.imem_we, if_a.imem_addr, if_a.imem_wdata); end
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        n_checks++; if (done_a !== 1'b1) begin n_errors++; $display("FAIL start_at_done_enter: got done=%b want 1", done_a); end
        tick();
        n_checks++; if ({done_a, hold_a, if_a.in_ready} !== 3'b011) begin n_errors++; $display("FAIL start_at_done_reload: got done/hold/ready=%b want 011", {done_a, hold_a, if_a.in_ready}); end
    endtask

    task automatic test_illegal();
        beat_a(3'd3, 5'd0, 5'd1, 5'd1, 3'd0, 1'b0, 3, 1'b0);
        tick();
        n_checks++; if ({if_a.imem_we, err_a} !== 2'b01) begin n_errors++; $display("FAIL beq_odd: got we/err=%b want 01", {if_a.imem_we, err_a}); end
        beat_a(3'd7, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 0, 1'b0);
        tick();
        n_checks++; if ({if_a.imem_we, err_a, if_a.in_ready} !== 3'b011) begin n_errors++; $display("FAIL kind7: got we/err/ready=%b want 011", {if_a.imem_we, err_a, if_a.in_ready}); end
        beat_a(3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, -2048, 1'b0);
        tick();
        n_checks++; if ({if_a.imem_we, if_a.imem_addr, if_a.imem_wdata} !== {1'b1, 6'd0, 32'h80002003}) begin n_errors++; $display("FAIL lw_min_imm: got we=%b addr=%0d data=%h want 1/0/80002003", if_a.imem_we, if_a.imem_addr, if_a.imem_wdata); end
        beat_a(3'd4, 5'd1, 5'd2, 5'd9, 3'd5, 1'b1, 3, 1'b0);
        tick();
        n_checks++; if ({if_a.imem_we, if_a.imem_addr, if_a.imem_wdata} !== {1'b1, 6'd1, 32'h40315093}) begin n_errors++; $display("FAIL srai: got we=%b addr=%0d data=%h want 1/1/40315093", if_a.imem_we, if_a.imem_addr, if_a.imem_wdata); end
        beat_a(3'd0, 5'd1, 5'd1, 5'd0, 3'd0, 1'b0, 2048, 1'b1);
        tick();
        if_a.in_valid = 1'b0;
        n_checks++; if ({if_a.imem_we, done_a, err_a} !== 3'b011) begin n_errors++; $display("FAIL illegal_last: got we/done/err=%b want 011", {if_a.imem_we, done_a, err_a}); end
        pulse_start_a();
        n_checks++; if ({err_a, if_a.in_ready} !== 2'b01) begin n_errors++; $display("FAIL err_cleared: got err/ready=%b want 01", {err_a, if_a.in_ready}); end
    endtask

    task automatic test_full();
        int writes = 0;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        if_b.in_valid    = 1'b1;
        if_b.in_kind     = 3'd0;
        if_b.in_rs1      = 5'd0;
        if_b.in_rs2      = 5'd0;
        if_b.in_funct3   = 3'd0;
        if_b.in_funct7b5 = 1'b0;
        if_b.in_imm      = 21'd0;
        if_b.in_last     = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if_b.in_rd = 5'(i);
            tick();
            if (if_b.imem_we === 1'b1) writes++;
            if (i < 4) begin
                n_checks++;
                if ({if_b.imem_addr, if_b.imem_wdata} !== {2'(i), 32'h00002003 | (32'(i) << 7)}) begin
                    n_errors++; $display("FAIL full_write%0d: got addr=%0d data=%h want %0d/%h", i, if_b.imem_addr, if_b.imem_wdata, i, 32'h00002003 | (32'(i) << 7));
                end
            end
            if (i == 3) begin
                n_checks++; if (if_b.in_ready !== 1'b0) begin n_errors++; $display("FAIL full_ready: got %b want 0", if_b.in_ready); end
            end
        end
        if_b.in_valid = 1'b0;
        n_checks++; if (writes != 4) begin n_errors++; $display("FAIL full_count: got %0d writes want 4", writes); end
        n_checks++; if ({done_b, hold_b} !== 2'b10) begin n_errors++; $display("FAIL full_done: got done/hold=%b want 10", {done_b, hold_b}); end
    endtask

    task automatic test_reset_mid();
        beat_a(3'd0, 5'd5, 5'd2, 5'd0, 3'd0, 1'b0, 8, 1'b0);
        tick();
        if_a.in_valid = 1'b0;
        reset = 1'b0;
        #1;
        n_checks++; if (if_a.imem_we !== 1'b0) begin n_errors++; $display("FAIL mid_rst_we: got %b want 0", if_a.imem_we); end
        tick();
        reset = 1'b1;
        tick();
        n_checks++; if ({if_a.imem_we, hold_a, done_a, if_a.in_ready} !== 4'b0100) begin n_errors++; $display("FAIL mid_rst_idle: got we/hold/done/ready=%b want 0100", {if_a.imem_we, hold_a, done_a, if_a.in_ready}); end
        n_checks++; if (if_a.imem_addr !== 6'd0) begin n_errors++; $display("FAIL mid_rst_addr: got %0d want 0", if_a.imem_addr); end
    endtask

    initial begin
        if_a.in_valid = 1'b0; if_a.in_kind = 3'd0; if_a.in_rd = 5'd0; if_a.in_rs1 = 5'd0;
        if_a.in_rs2 = 5'd0; if_a.in_funct3 = 3'd0; if_a.in_funct7b5 = 1'b0; if_a.in_imm = 21'd0;
        if_a.in_last = 1'b0;
        if_b.in_valid = 1'b0; if_b.in_kind = 3'd0; if_b.in_rd = 5'd0; if_b.in_rs1 = 5'd0;
        if_b.in_rs2 = 5'd0; if_b.in_funct3 = 3'd0; if_b.in_funct7b5 = 1'b0; if_b.in_imm = 21'd0;
        if_b.in_last = 1'b0;
        test_reset();
        test_lw();
        test_back_to_back();
        test_branch_jal_start_at_done();
        test_illegal();
        test_full();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
